// File: rtl/modcnt_pkg.sv
// Shared constants and helpers for the modulo counter.
package modcnt_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Width used for clamping so one function serves every counter width.
    localparam int unsigned CLAMP_W = 64;

    // Clamp a load value to the terminal value.
    function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] val,
                                                      input logic [CLAMP_W-1:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/modulo_counter_if.sv
// Control and status bundle of the modulo counter.
interface modulo_counter_if #(
    parameter int WIDTH = 8
);
    import modcnt_pkg::*;

    logic             en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up_dn;
    logic             sat;
    logic [WIDTH-1:0] cnt;
    logic             reached;
    logic             zero;
    logic             tc;

    modport master (
        output en, clr, load, load_val, up_dn, sat,
        input  cnt, reached, zero, tc
    );

    modport slave (
        input  en, clr, load, load_val, up_dn, sat,
        output cnt, reached, zero, tc
    );

endinterface

// File: rtl/modcnt_prescaler.sv
// Clock-enable prescaler: tick is high once every PRESCALE enabled cycles.
// Only instantiated when MODCNT_PRESCALE_EN is defined.
module modcnt_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick = (pre_q == LAST);

    // Next prescaler value: clear wins, otherwise advance on enabled cycles.
    always_comb begin
        pre_d = pre_q;
        if (sync_clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/modulo_counter.sv
// Registered up/down modulo counter with wrap/saturate, clear, load and a
// terminal-count pulse. Define MODCNT_PRESCALE_EN to add the prescaler.
module modulo_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 8,
    parameter int PRESCALE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    modulo_counter_if.slave        bus
);
    import modcnt_pkg::*;

    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    if (WIDTH < 1) begin : g_bad_width
        $error("modulo_counter: WIDTH must be >= 1");
    end
    if (MAX_VAL <= 0 || (WIDTH < 31 && MAX_VAL >= (1 << WIDTH))) begin : g_bad_max
        $error("modulo_counter: MAX_VAL must be in 1 .. 2**WIDTH-1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("modulo_counter: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tc_q;
    logic             tc_d;
    logic             tick;
    logic             step;
    logic [WIDTH-1:0] load_clamped;

`ifdef MODCNT_PRESCALE_EN
    modcnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .sync_clr (bus.clr | bus.load),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign step         = bus.en & tick;
    assign load_clamped = WIDTH'(clamp_load(CLAMP_W'(bus.load_val), CLAMP_W'(MAX_VAL)));

    // Next count and terminal pulse: clr > load > step > hold.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (bus.load) begin
            cnt_d = load_clamped;
        end else if (step) begin
            if (bus.up_dn == DIR_UP) begin
                if (cnt_q < MAX_L) begin
                    cnt_d = cnt_q + ONE;
                    tc_d  = (bus.sat == MODE_SAT) && (cnt_q + ONE == MAX_L);
                end else if (bus.sat == MODE_WRAP) begin
                    cnt_d = '0;
                    tc_d  = 1'b1;
                end
            end else if (bus.up_dn == DIR_DOWN) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                    tc_d  = (bus.sat == MODE_SAT) && (cnt_q == ONE);
                end else if (bus.sat == MODE_WRAP) begin
                    cnt_d = MAX_L;
                    tc_d  = 1'b1;
                end
            end
        end
    end

    // Count and terminal-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign bus.cnt     = cnt_q;
    assign bus.tc      = tc_q;
    assign bus.reached = (cnt_q == MAX_L);
    assign bus.zero    = (cnt_q == '0);

endmodule

// File: doc/modulo_counter.md
# modulo_counter

Parametrised, registered modulo counter: the sequential successor to the combinational 8-bit next-count block, which counted to a fixed 8 and cleared on idle. It adds configurable width and terminal value, up/down direction, wrap or saturate mode, synchronous clear and load, a terminal-count pulse and an optional clock-enable prescaler. It is used as a general-purpose event/timebase counter inside control FSMs and timers.

## Interface
- WIDTH, 8: counter width in bits (≥1)
- MAX_VAL, 8: terminal value of the up-count, inclusive; elaboration error if MAX_VAL ≥ 2^WIDTH or MAX_VAL = 0
- PRESCALE, 1: count every PRESCALE-th enabled cycle (≥1); used only with MODCNT_PRESCALE_EN
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable; low = hold (the count is not cleared)
- clr  in  1  synchronous clear to 0
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  load value; values > MAX_VAL are clamped to MAX_VAL
- up_dn  in  1  1 = count up, 0 = count down
- sat  in  1  1 = saturate at terminal value, 0 = wrap
- cnt  out  WIDTH  registered count
- reached  out  1  combinational, cnt == MAX_VAL
- zero  out  1  combinational, cnt == 0
- tc  out  1  registered one-cycle terminal-count pulse

## Operation
- Priority per edge: rst > clr > load > step > hold.
- step = en && tick; tick = 1 every cycle unless prescaling is compiled in.
- Up step:
  - cnt < MAX_VAL: cnt+1.
  - cnt == MAX_VAL, sat=0: cnt → 0 and tc=1.
  - cnt == MAX_VAL, sat=1: hold, tc=0.
- Down step:
  - cnt > 0: cnt−1.
  - cnt == 0, sat=0: cnt → MAX_VAL and tc=1.
  - cnt == 0, sat=1: hold, tc=0.
- In saturate mode, tc=1 on the step that lands on the terminal value: MAX_VAL when counting up, 0 when counting down.
- tc=0 on any cycle with no step, and on clr or load.
- up_dn and sat are sampled each step. Changing them mid-count takes effect on the next step with no flush.
- All arithmetic is WIDTH bits. The count never exceeds MAX_VAL, so no carry-out is needed.

## Timing
- Reset values: cnt=0, tc=0, prescaler=0. Hence reached=0 and zero=1 during reset.
- Latency:
  - cnt updates on the edge after step, clr or load.
  - tc is asserted in the same cycle as the cnt value it describes (registered alongside cnt).
  - reached and zero follow cnt combinationally, with no extra cycle.
- rst asserted mid-count clears immediately, asynchronously. Counting resumes on the first edge after deassertion with en=1.
- clr and load asserted together: clr wins.
- load with en=1: load wins and no step occurs that cycle.

## Configuration
- MODCNT_PRESCALE_EN defined:
  - An internal prescaler of max(1, clog2(PRESCALE)) bits advances only on en=1 cycles.
  - tick=1 when prescaler == PRESCALE−1, then the prescaler returns to 0.
  - clr and load reset the prescaler to 0. en=0 holds it.
  - PRESCALE=1 behaves exactly like the macro being absent.
- MODCNT_PRESCALE_EN undefined: no prescaler logic; tick is tied to 1; PRESCALE is ignored.

## Structure
- Package modcnt_pkg holds:
  - constants DIR_UP=1 and DIR_DOWN=0, MODE_WRAP=0 and MODE_SAT=1;
  - the clamp function for load_val.
- Sub-module modcnt_prescaler (params PRESCALE; ports clk, rst, en, sync_clr, tick) is instantiated only under MODCNT_PRESCALE_EN.

## Test plan
- Defaults (WIDTH=8, MAX_VAL=8), up, wrap, en=1 held for 20 cycles → cnt 0..8,0..8,0,1. tc high only in the cycles where cnt returns to 0. reached high only at 8.
- Down, sat=1, load_val=3 then en=1 → cnt 3,2,1,0,0,0. tc high once, when cnt becomes 0. zero stays high.
- Down, wrap, from 0 → cnt 8 with tc=1. load_val=200 → cnt 8 (clamped).
- en toggled 1,0,0,1 at cnt=4 → cnt 5,5,5,6 (hold, no clear). clr and load together at cnt=6 → cnt 0.
- rst pulse asynchronously mid-cycle at cnt=7 → cnt=0 and tc=0 before the next edge. Counting resumes from 1 on the first enabled edge after release.
- MODCNT_PRESCALE_EN with PRESCALE=3, en=1 for 9 cycles → cnt steps 0,0,1,1,1,2,2,2,3. With en dropped for 2 cycles mid-period, the period stretches by exactly 2 cycles.
